main_dot_v2: RTL and testbench

Streaming dot-product engine for one hidden layer of the network datapath. Each accepted beat multiplies six signed 16-bit data elements by six signed 16-bit weights and sums them into one 16-bit result. Results fill a 24-slot output vector, one slot per beat. `valid` pulses once all 24 slots of a frame are written.

---
 rtl/main_dot_v2_pkg.sv | 27 ++
 rtl/main_dot_v2_dot_lane_mul.sv | 33 +++
 rtl/main_dot_v2.sv | 97 +++++++++
 tb/tb_main_dot_v2.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/main_dot_v2_pkg.sv
// Shared parameters and types for the main_dot_v2 streaming dot-product engine.
//   BIT_LENGTH : element width (two's complement)
//   DATA_N     : elements per beat
//   HID_LENGTH : result slots per frame
package main_dot_v2_pkg;

  localparam int unsigned BIT_LENGTH = 16;
  localparam int unsigned DATA_N     = 6;
  localparam int unsigned HID_LENGTH = 24;
  localparam int unsigned IDX_W      = $clog2(HID_LENGTH);
  localparam int unsigned PROD_W     = 2 * BIT_LENGTH;
  localparam int unsigned SUM_W      = PROD_W + $clog2(DATA_N);
  localparam int unsigned VEC_W      = DATA_N * BIT_LENGTH;
  localparam int unsigned OUT_W      = HID_LENGTH * BIT_LENGTH;

  // One accepted beat: six packed elements and their six weights.
  typedef struct packed {
    logic [VEC_W-1:0] data;
    logic [VEC_W-1:0] weight;
  } beat_t;

  // Slot index advance with wrap after the last slot of a frame.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(HID_LENGTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/main_dot_v2_dot_lane_mul.sv
// One registered signed BIT_LENGTH x BIT_LENGTH -> PROD_W multiplier lane.
//   clk, rst_n : clock, async active-low reset
//   en         : load a new product this cycle
//   a_in, b_in : signed operands
//   prod       : registered signed product
module dot_lane_mul
  import main_dot_v2_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [BIT_LENGTH-1:0] a_in,
  input  logic signed [BIT_LENGTH-1:0] b_in,
  output logic signed [PROD_W-1:0] prod
);

  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] prod_q;

  // Product only reloads on a live beat; holds otherwise.
  always_comb begin
    prod_d = prod_q;
    if (en) prod_d = PROD_W'(a_in) * PROD_W'(b_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod_q <= '0;
    else        prod_q <= prod_d;
  end

  assign prod = prod_q;

endmodule

// File: rtl/main_dot_v2.sv
// Streaming dot-product engine: each beat of six signed elements/weights yields
// one wrapped 16-bit sum written to the next slot of a 24-slot result vector.
//   clk, rst_n : clock, async active-low reset
//   run        : beat qualifier for data_in/weight_in
//   data_in    : six signed elements, lane i = [16i+15:16i]
//   weight_in  : six signed weights, same packing
//   valid      : one-cycle pulse when slot 23 is written
//   data_out   : result vector, slot k = [16k+15:16k]
module main_dot_v2
  import main_dot_v2_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [VEC_W-1:0] data_in,
  input  logic [VEC_W-1:0] weight_in,
  output logic             valid,
  output logic [OUT_W-1:0] data_out
);

  beat_t             beat_d, beat_q;
  logic              beat_vld_d, beat_vld_q;
  logic              prod_vld_d, prod_vld_q;
  logic [IDX_W-1:0]  wr_idx_d, wr_idx_q;
  logic              valid_d, valid_q;
  logic [OUT_W-1:0]  data_out_d, data_out_q;

  logic signed [PROD_W-1:0] outdot_array [DATA_N];
  logic signed [SUM_W-1:0]  sum_c;
  logic                     unused_sum_hi_c;

  // Per-lane registered multipliers fed from the captured beat.
  for (genvar i = 0; i < int'(DATA_N); i++) begin : g_lane
    dot_lane_mul u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (beat_vld_q),
      .a_in  (beat_q.data[i*BIT_LENGTH +: BIT_LENGTH]),
      .b_in  (beat_q.weight[i*BIT_LENGTH +: BIT_LENGTH]),
      .prod  (outdot_array[i])
    );
  end

  // Full-width signed sum of the lane products; only the low bits are kept.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(DATA_N); i++) begin
      sum_c = sum_c + SUM_W'(outdot_array[i]);
    end
  end

  assign unused_sum_hi_c = ^sum_c[SUM_W-1:BIT_LENGTH];

  // Input capture, pipeline valid bits, slot write, index and frame pulse.
  always_comb begin
    beat_d     = beat_q;
    beat_vld_d = run;
    prod_vld_d = beat_vld_q;
    wr_idx_d   = wr_idx_q;
    valid_d    = 1'b0;
    data_out_d = data_out_q;

    if (run) beat_d = '{data: data_in, weight: weight_in};

    if (prod_vld_q) begin
      for (int k = 0; k < int'(HID_LENGTH); k++) begin
        if (wr_idx_q == IDX_W'(k)) begin
          data_out_d[k*BIT_LENGTH +: BIT_LENGTH] = sum_c[BIT_LENGTH-1:0];
        end
      end
      valid_d  = (wr_idx_q == IDX_W'(HID_LENGTH - 1));
      wr_idx_d = next_idx(wr_idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q     <= '0;
      beat_vld_q <= 1'b0;
      prod_vld_q <= 1'b0;
      wr_idx_q   <= '0;
      valid_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      beat_q     <= beat_d;
      beat_vld_q <= beat_vld_d;
      prod_vld_q <= prod_vld_d;
      wr_idx_q   <= wr_idx_d;
      valid_q    <= valid_d;
      data_out_q <= data_out_d;
    end
  end

  assign valid    = valid_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_main_dot_v2.sv
// Self-checking bench for main_dot_v2: frame-level model plus literal spot checks.
module tb_main_dot_v2;

  logic         clk;
  logic         rst_n;
  logic         run;
  logic [95:0]  data_in;
  logic [95:0]  weight_in;
  logic         valid;
  logic [383:0] data_out;

  int tests = 0;
  int fails = 0;
  int vcount = 0;

  main_dot_v2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .data_in   (data_in),
    .weight_in (weight_in),
    .valid     (valid),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model: slots, write index, in-flight results ----------
  typedef struct {
    int          due;
    logic [15:0] val;
  } pend_t;

  pend_t       pend[$];
  logic [15:0] slots [24];
  int          widx = 0;
  int          cyc = 0;
  logic        exp_valid = 1'b0;

  function automatic logic [15:0] dot16(input logic [95:0] d, input logic [95:0] w);
    longint s = 0;
    for (int i = 0; i < 6; i++) begin
      s += longint'($signed(d[i*16 +: 16])) * longint'($signed(w[i*16 +: 16]));
    end
    return s[15:0];
  endfunction

  function automatic logic [383:0] model_vec();
    logic [383:0] v = '0;
    for (int k = 0; k < 24; k++) v[k*16 +: 16] = slots[k];
    return v;
  endfunction

  function automatic logic [15:0] slot_of(input logic [383:0] v, input int k);
    return v[k*16 +: 16];
  endfunction

  initial begin
    for (int k = 0; k < 24; k++) slots[k] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend.delete();
        for (int k = 0; k < 24; k++) slots[k] = '0;
        widx = 0;
        exp_valid = 1'b0;
      end else begin
        cyc++;
        exp_valid = 1'b0;
        while (pend.size() > 0 && pend[0].due == cyc) begin
          slots[widx] = pend[0].val;
          if (widx == 23) exp_valid = 1'b1;
          widx = (widx + 1) % 24;
          void'(pend.pop_front());
        end
        if (run) pend.push_back('{due: cyc + 2, val: dot16(data_in, weight_in)});
      end
    end
  end

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("data_out_vs_model", data_out, model_vec());
      chk("valid_vs_model", 384'(valid), 384'(exp_valid));
      if (valid === 1'b1) vcount++;
    end
  end

  // ---------------- stimulus ----------------
  int d_tab [8][6] = '{
    '{-9, -8, -5, -1, -5, -3},
    '{-4, -3, -2, -1, -6, -5},
    '{-1, -9, -5, -2, -14, -8},
    '{1, 2, 3, 4, 5, 6},
    '{100, 0, 0, 0, 0, 0},
    '{2, 2, 2, 2, 2, 2},
    '{1000, 1000, 0, 0, 0, 0},
    '{7, 8, 5, 6, 12, 12}
  };
  int w_tab [8][6] = '{
    '{5, 3, 2, 9, 5, 2},
    '{2, 1, 5, 4, 2, 2},
    '{6, 5, 2, 1, 7, 5},
    '{1, 1, 1, 1, 1, 1},
    '{-3, 0, 0, 0, 0, 0},
    '{-1, -1, -1, -1, -1, -1},
    '{40, -7, 0, 0, 0, 0},
    '{2, 6, 11, 8, 9, 2}
  };

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    run = 1'b0;
    repeat (n) step();
  endtask

  task automatic beat(input int d[6], input int w[6]);
    for (int i = 0; i < 6; i++) begin
      data_in[i*16 +: 16]   = 16'(d[i]);
      weight_in[i*16 +: 16] = 16'(w[i]);
    end
    run = 1'b1;
    step();
  endtask

  task automatic gen_beat(input int k);
    int d[6];
    int w[6];
    for (int i = 0; i < 6; i++) begin
      d[i] = ((k * 37 + i * 101) % 2001) - 1000;
      w[i] = ((k * 53 + i * 29) % 601) - 300;
    end
    beat(d, w);
  endtask

  initial begin
    int d1[6];
    int w1[6];
    int v0;
    rst_n = 1'b0;
    run = 1'b0;
    data_in = '0;
    weight_in = '0;

    repeat (12) step();
    chk("reset_data_out", data_out, '0);
    chk("reset_valid", 384'(valid), 384'(0));
    rst_n = 1'b1;
    step();

    // First eight beats back-to-back
    for (int b = 0; b < 8; b++) beat(d_tab[b], w_tab[b]);
    idle(2);
    chk("slot0", 384'(slot_of(data_out, 0)), 384'(16'hFF89));
    chk("slot1", 384'(slot_of(data_out, 1)), 384'(16'hFFD1));
    chk("slot2", 384'(slot_of(data_out, 2)), 384'(16'hFF37));
    chk("slot3", 384'(slot_of(data_out, 3)), 384'(16'h0015));
    chk("slot4", 384'(slot_of(data_out, 4)), 384'(16'hFED4));
    chk("slot5", 384'(slot_of(data_out, 5)), 384'(16'hFFF4));
    chk("slot6_wrap", 384'(slot_of(data_out, 6)), 384'(16'h80E8));
    chk("slot7", 384'(slot_of(data_out, 7)), 384'(16'h0129));
    chk("slots8_23_zero", 384'(data_out[383:128]), '0);
    chk("no_valid_yet", 384'(vcount), 384'(0));

    // Remaining 16 beats of the frame, with one bubble in the middle
    for (int k = 8; k < 24; k++) begin
      gen_beat(k);
      if (k == 12) idle(1);
    end
    run = 1'b0;
    step();
    chk("valid_n_plus_1", 384'(valid), 384'(0));
    step();
    chk("valid_n_plus_2", 384'(valid), 384'(1));
    step();
    chk("valid_one_cycle", 384'(valid), 384'(0));
    chk("valid_count_frame1", 384'(vcount), 384'(1));

    // Beat 25 overwrites slot 0
    d1 = '{3, 0, 0, 0, 0, 0};
    w1 = '{7, 0, 0, 0, 0, 0};
    beat(d1, w1);
    idle(2);
    chk("slot0_overwrite", 384'(slot_of(data_out, 0)), 384'(16'h0015));

    // Overflow: all lanes 0x7FFF * 0x7FFF into slot 1
    d1 = '{32767, 32767, 32767, 32767, 32767, 32767};
    w1 = '{32767, 32767, 32767, 32767, 32767, 32767};
    beat(d1, w1);
    idle(2);
    chk("slot1_overflow", 384'(slot_of(data_out, 1)), 384'(16'h0006));

    // Mid-frame reset after ten beats
    for (int k = 30; k < 40; k++) gen_beat(k);
    run = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("async_reset_clear", data_out, '0);
    chk("async_reset_valid", 384'(valid), 384'(0));
    rst_n = 1'b1;
    step();
    v0 = vcount;
    beat(d_tab[0], w_tab[0]);
    for (int k = 41; k < 64; k++) gen_beat(k);
    run = 1'b0;
    step();
    chk("post_reset_no_early_valid", 384'(vcount), 384'(v0));
    step();
    chk("post_reset_valid", 384'(valid), 384'(1));
    chk("post_reset_slot0", 384'(slot_of(data_out, 0)), 384'(16'hFF89));
    idle(3);
    chk("post_reset_valid_count", 384'(vcount), 384'(v0 + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
